// File: rtl/uo_arb_pkg.sv
// Shared definitions for the uo_out arbitration logic: FSM state type and
// the wrap-around round-robin search used by rr_pick.
package uo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Largest requester count the search helper supports.
  localparam int unsigned RR_MAX = 8;

  // First asserted index searching ptr, ptr+1, ... n-1, 0, ... (n <= RR_MAX).
  // Returns 0 when nothing is requested; callers qualify with |req.
  function automatic int unsigned rr_search(input logic [RR_MAX-1:0] req,
                                            input logic [2:0]        ptr,
                                            input int unsigned       n);
    int unsigned idx;
    int unsigned cand;
    logic        found;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      cand = (32'(ptr) + i) % n;
      if (!found && (i < n) && req[cand[2:0]]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/uo_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot select and index of the first
// active request at or after ptr, with wrap-around.
module rr_pick
  import uo_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [RR_MAX-1:0] req_ext;
  logic [2:0]        ptr_ext;

  // Widen to the helper's fixed width, search, then build the one-hot select.
  always_comb begin
    req_ext          = '0;
    req_ext[N-1:0]   = req;
    ptr_ext          = '0;
    ptr_ext[IW-1:0]  = ptr;
    any              = |req;
    idx              = IW'(rr_search(req_ext, ptr_ext, N));
    onehot           = '0;
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/uo_rr_arbiter.sv
// Round-robin arbiter sharing the registered uo_out byte bus between N_REQ
// requesters. One grant at a time; release on last, MAX_BURST or req drop.
module uo_rr_arbiter
  import uo_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DW         = 8,
  parameter int unsigned MAX_BURST  = 16,
  parameter logic [DW-1:0] IDLE_VALUE = 8'h00,
  localparam int unsigned IW        = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  last,
  input  logic [N_REQ*DW-1:0] data,
  output logic [N_REQ-1:0]  gnt,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  output logic [IW-1:0]     owner
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  arb_state_e       state;
  logic [IW-1:0]    ptr;
  logic [CW-1:0]    cnt;

  logic [N_REQ-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  logic [DW-1:0]    data_arr [N_REQ];
  logic             beat;
  logic             release_now;
  logic [CW-1:0]    cnt_next;
  logic [IW-1:0]    ptr_after;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Unpack the beat data so the owner's byte can be selected by index.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      data_arr[i] = data[i*DW +: DW];
    end
  end

  // Beat acceptance and release conditions for the current owner.
  always_comb begin
    beat        = (state == GRANT) && gnt[owner] && req[owner];
    cnt_next    = cnt + 1'b1;
    release_now = (state == GRANT) &&
                  ((beat && (last[owner] || (cnt_next == CW'(MAX_BURST)))) ||
                   !req[owner]);
    ptr_after   = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
  end

  // Grant FSM, burst counter, round-robin pointer and registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      owner     <= '0;
      ptr       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= IDLE_VALUE;
    end else begin
      out_valid <= 1'b0;
      out_data  <= IDLE_VALUE;
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt   <= pick_onehot;
            owner <= pick_idx;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (beat) begin
            out_valid <= 1'b1;
            out_data  <= data_arr[owner];
            cnt       <= cnt_next;
          end
          // Release overrides the counter update so it restarts from zero.
          if (release_now) begin
            gnt   <= '0;
            ptr   <= ptr_after;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
